i2c_txn_arbiter: RTL and testbench

Shares one I2C byte-engine (the `i2c_com` engine: 32-bit command word, `start`/`tr_end`/`ack` handshake) between `NREQ` requesters. Typical requesters are the boot-time camera LUT sequencer and runtime register writers such as exposure or white-balance updates. The block generates the engine's I2C clock from `clk_24M`, grants requesters round-robin, and sequences each transaction. It reports per-transaction completion with a NACK/timeout status. It sits between the camera configuration logic and the engine instance.

---
 rtl/i2c_txn_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: shares one i2c_com byte engine between NREQ requesters.
// Generates the engine clock, grants round-robin, sequences each transfer.
//
// Ports:
//   clk_24M, camera_rstn          clock, async active-low reset
//   req_valid/req_data/req_ready  per-requester command handshake
//   resp_valid/resp_err           per-requester completion pulse, NACK/timeout
//   busy                          transaction in flight
//   i2c_clk, eng_start, eng_data  engine clock, start level, command word
//   eng_tr_end, eng_ack           engine status (i2c_clk domain, synced here)
module i2c_txn_arbiter #(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned DIV         = 1200,
    parameter int unsigned TIMEOUT_CYC = 2400000
) (
    input  logic                 clk_24M,
    input  logic                 camera_rstn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    output logic                 resp_err,
    output logic                 busy,
    output logic                 i2c_clk,
    output logic                 eng_start,
    output logic [31:0]          eng_data,
    input  logic                 eng_tr_end,
    input  logic                 eng_ack
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW = $clog2(DIV + 1);
    localparam int unsigned REL_CYC = 2 * (DIV + 1);
    localparam int unsigned CNT_MAX =
        (TIMEOUT_CYC > REL_CYC) ? TIMEOUT_CYC : REL_CYC;
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] REL_LAST = CW'(REL_CYC - 1);
    localparam logic [PW-1:0] PTR_RST  = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_END,
        S_RELEASE
    } state_t;

    state_t          r_state, w_state;
    logic [PW-1:0]   r_ptr, w_ptr;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic            r_err, w_err;
    logic            r_start, w_start;
    logic [31:0]     r_data, w_data;
    logic [NREQ-1:0] r_req_ready, w_req_ready;
    logic [NREQ-1:0] r_resp_valid, w_resp_valid;
    logic            r_resp_err, w_resp_err;

    logic [DW-1:0]   r_div;
    logic            r_i2c_clk;
    logic            r_tr_s1, r_tr_s;
    logic            r_ack_s1, r_ack_s;

    logic            w_found;
    logic [PW-1:0]   w_gnt;
    logic [PW:0]     w_k;

    // Free-running engine clock; runs regardless of arbiter state.
    always_ff @(posedge clk_24M or negedge camera_rstn) begin
        if (!camera_rstn) begin
            r_div     <= '0;
            r_i2c_clk <= 1'b0;
        end else if (r_div == DIV_LAST) begin
            r_div     <= '0;
            r_i2c_clk <= ~r_i2c_clk;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    always_ff @(posedge clk_24M or negedge camera_rstn) begin
        if (!camera_rstn) begin
            r_tr_s1  <= 1'b0;
            r_tr_s   <= 1'b0;
            r_ack_s1 <= 1'b0;
            r_ack_s  <= 1'b0;
        end else begin
            r_tr_s1  <= eng_tr_end;
            r_tr_s   <= r_tr_s1;
            r_ack_s1 <= eng_ack;
            r_ack_s  <= r_ack_s1;
        end
    end

    // Round-robin pick: first set request after the last granted one.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_k     = '0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            w_k = {1'b0, r_ptr} + (PW + 1)'(i);
            if (w_k >= (PW + 1)'(NREQ)) begin
                w_k = w_k - (PW + 1)'(NREQ);
            end
            if (!w_found && req_valid[w_k[PW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_k[PW-1:0];
            end
        end
    end

    always_comb begin
        w_state      = r_state;
        w_ptr        = r_ptr;
        w_cnt        = r_cnt;
        w_err        = r_err;
        w_start      = r_start;
        w_data       = r_data;
        w_req_ready  = '0;
        w_resp_valid = '0;
        w_resp_err   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    for (int i = 0; i < int'(NREQ); i++) begin
                        if (w_gnt == PW'(i)) begin
                            w_data         = req_data[32*i +: 32];
                            w_req_ready[i] = 1'b1;
                        end
                    end
                    w_ptr   = w_gnt;
                    w_state = S_START;
                end
            end
            S_START: begin
                w_start = 1'b1;
                w_cnt   = '0;
                w_state = S_WAIT_END;
            end
            S_WAIT_END: begin
                w_cnt = r_cnt + CW'(1);
                // A real completion beats a coincident timeout.
                if (r_tr_s) begin
                    w_err   = r_ack_s;
                    w_start = 1'b0;
                    w_cnt   = '0;
                    w_state = S_RELEASE;
                end else if (r_cnt == TO_LAST) begin
                    w_err   = 1'b1;
                    w_start = 1'b0;
                    w_cnt   = '0;
                    w_state = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Hold off until the engine has seen start low on at
                // least one i2c_clk edge; counter saturates if it hangs.
                if (r_cnt != REL_LAST) begin
                    w_cnt = r_cnt + CW'(1);
                end
                if (!r_tr_s && r_cnt == REL_LAST) begin
                    for (int i = 0; i < int'(NREQ); i++) begin
                        w_resp_valid[i] = (r_ptr == PW'(i));
                    end
                    w_resp_err = r_err;
                    w_state    = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_24M or negedge camera_rstn) begin
        if (!camera_rstn) begin
            r_state      <= S_IDLE;
            r_ptr        <= PTR_RST;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_start      <= 1'b0;
            r_data       <= '0;
            r_req_ready  <= '0;
            r_resp_valid <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_ptr        <= w_ptr;
            r_cnt        <= w_cnt;
            r_err        <= w_err;
            r_start      <= w_start;
            r_data       <= w_data;
            r_req_ready  <= w_req_ready;
            r_resp_valid <= w_resp_valid;
            r_resp_err   <= w_resp_err;
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign busy       = (r_state != S_IDLE);
    assign i2c_clk    = r_i2c_clk;
    assign eng_start  = r_start;
    assign eng_data   = r_data;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter with a behavioural engine model.
// Expected grants/responses are queued at issue time, popped by a monitor.
module tb_i2c_txn_arbiter;

    localparam int NREQ = 2;
    localparam int DIV  = 4;
    localparam int TOC  = 100;

    logic              clk_24M = 1'b0;
    logic              camera_rstn = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [32*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   resp_valid;
    logic              resp_err;
    logic              busy;
    logic              i2c_clk;
    logic              eng_start;
    logic [31:0]       eng_data;
    logic              eng_tr_end = 1'b0;
    logic              eng_ack = 1'b0;

    i2c_txn_arbiter #(
        .NREQ(NREQ), .DIV(DIV), .TIMEOUT_CYC(TOC)
    ) dut (
        .clk_24M(clk_24M),
        .camera_rstn(camera_rstn),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .resp_valid(resp_valid),
        .resp_err(resp_err),
        .busy(busy),
        .i2c_clk(i2c_clk),
        .eng_start(eng_start),
        .eng_data(eng_data),
        .eng_tr_end(eng_tr_end),
        .eng_ack(eng_ack)
    );

    always #5 clk_24M = ~clk_24M;

    typedef struct { int idx; logic [31:0] data; } gexp_t;
    typedef struct { int idx; logic err; int gap_rel; int gap_on; } rexp_t;

    gexp_t       gq[$];
    rexp_t       respq[$];
    logic [31:0] rq0[$];
    logic [31:0] rq1[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   t_rise  = 0;
    int   t_fall  = 0;
    logic prev_start = 1'b0;

    int   cfg_per  = 3;
    logic cfg_ack  = 1'b0;
    logic cfg_hang = 1'b0;
    int   cfg_drop = 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic issue(input int idx, input logic [31:0] d,
                         input logic err, input int gap_rel,
                         input int gap_on, input bit want_resp);
        gexp_t g;
        rexp_t r;
        if (idx == 0) rq0.push_back(d);
        else          rq1.push_back(d);
        g.idx = idx;
        g.data = d;
        gq.push_back(g);
        if (want_resp) begin
            r.idx = idx;
            r.err = err;
            r.gap_rel = gap_rel;
            r.gap_on = gap_on;
            respq.push_back(r);
        end
    endtask

    task automatic wait_done(input string name, input int maxc);
        int n = 0;
        do begin
            @(negedge clk_24M);
            n++;
        end while (!(gq.size() == 0 && respq.size() == 0 &&
                     rq0.size() == 0 && rq1.size() == 0 && !busy)
                   && n < maxc);
        if (n >= maxc) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no completion within %0d cycles", name, maxc);
        end
        repeat (2) @(negedge clk_24M);
    endtask

    task automatic apply_reset();
        @(posedge clk_24M);
        #3 camera_rstn = 1'b0;
        gq.delete();
        respq.delete();
        rq0.delete();
        rq1.delete();
        repeat (3) @(negedge clk_24M);
        camera_rstn = 1'b1;
        repeat (2) @(negedge clk_24M);
    endtask

    initial forever begin
        @(posedge clk_24M);
        cyc++;
    end

    // Requester drivers: hold valid until the matching ready pulse.
    initial forever begin
        @(negedge clk_24M);
        if (req_ready[0] && rq0.size() > 0) void'(rq0.pop_front());
        if (req_ready[1] && rq1.size() > 0) void'(rq1.pop_front());
        req_valid[0] = (rq0.size() > 0);
        req_valid[1] = (rq1.size() > 0);
        req_data[31:0]  = (rq0.size() > 0) ? rq0[0] : 32'h0;
        req_data[63:32] = (rq1.size() > 0) ? rq1[0] : 32'h0;
    end

    // Engine model: tr_end after cfg_per i2c_clk periods, drops it
    // cfg_drop cycles after start falls. Hang mode never asserts it.
    initial forever begin
        do @(negedge clk_24M); while (!eng_start);
        if (!cfg_hang) begin
            repeat (cfg_per) @(posedge i2c_clk);
            @(negedge clk_24M);
            eng_tr_end = 1'b1;
            eng_ack = cfg_ack;
        end
        do @(negedge clk_24M); while (eng_start);
        repeat (cfg_drop) @(negedge clk_24M);
        eng_tr_end = 1'b0;
        eng_ack = 1'b0;
    end

    initial begin : monitor
        gexp_t g;
        rexp_t r;
        forever begin
            @(negedge clk_24M);
            if (eng_start && !prev_start) t_rise = cyc;
            if (!eng_start && prev_start) t_fall = cyc;
            prev_start = eng_start;
            if (req_ready != '0) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", 32'(req_ready), 32'h0);
                end else begin
                    g = gq.pop_front();
                    chk("grant_idx", 32'(req_ready), 32'(1) << g.idx);
                    chk("eng_data", eng_data, g.data);
                end
            end
            if (resp_valid != '0) begin
                if (respq.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_valid), 32'h0);
                end else begin
                    r = respq.pop_front();
                    chk("resp_idx", 32'(resp_valid), 32'(1) << r.idx);
                    chk("resp_err", 32'(resp_err), 32'(r.err));
                    chk("release_gap", 32'(cyc - t_fall), 32'(r.gap_rel));
                    if (r.gap_on >= 0) begin
                        chk("start_width", 32'(t_fall - t_rise),
                            32'(r.gap_on));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        #1 camera_rstn = 1'b0;
        repeat (2) @(negedge clk_24M);
        chk("rst_i2c_clk", 32'(i2c_clk), 32'h0);
        chk("rst_eng_start", 32'(eng_start), 32'h0);
        chk("rst_eng_data", eng_data, 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        repeat (12) @(negedge clk_24M);
        chk("rst_i2c_clk_held", 32'(i2c_clk), 32'h0);
        camera_rstn = 1'b1;
        repeat (2) @(negedge clk_24M);

        // Single request
        @(posedge clk_24M); #1;
        issue(0, 32'h78300811, 1'b0, 10, -1, 1'b1);
        wait_done("single", 400);

        // Round-robin from reset, both held for 6 transactions
        apply_reset();
        @(posedge clk_24M); #1;
        for (int k = 0; k < 3; k++) begin
            issue(0, 32'hA0000000 + 32'(k), 1'b0, 10, -1, 1'b1);
            issue(1, 32'hB0000000 + 32'(k), 1'b0, 10, -1, 1'b1);
        end
        wait_done("round_robin", 2000);

        // NACK then a normal grant
        cfg_ack = 1'b1;
        @(posedge clk_24M); #1;
        issue(1, 32'hC0FFEE01, 1'b1, 10, -1, 1'b1);
        wait_done("nack", 400);
        cfg_ack = 1'b0;
        @(posedge clk_24M); #1;
        issue(0, 32'h12345678, 1'b0, 10, -1, 1'b1);
        wait_done("after_nack", 400);

        // Timeout: engine silent
        cfg_hang = 1'b1;
        @(posedge clk_24M); #1;
        issue(0, 32'hDEAD0001, 1'b1, 10, TOC, 1'b1);
        wait_done("timeout", 600);
        cfg_hang = 1'b0;

        // Late tr_end drop stretches the release
        cfg_drop = 20;
        @(posedge clk_24M); #1;
        issue(1, 32'h5A5A0002, 1'b0, 23, -1, 1'b1);
        wait_done("slow_drop", 400);
        cfg_drop = 1;

        // Reset in WAIT_END
        cfg_hang = 1'b1;
        @(posedge clk_24M); #1;
        issue(0, 32'h0BADF00D, 1'b0, 0, -1, 1'b0);
        n = 0;
        while (!eng_start && n < 200) begin
            @(negedge clk_24M);
            n++;
        end
        chk("mid_start_seen", 32'(eng_start), 32'h1);
        repeat (20) @(posedge clk_24M);
        chk("mid_busy_pre", 32'(busy), 32'h1);
        #3 camera_rstn = 1'b0;
        #1;
        chk("mid_rst_start", 32'(eng_start), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_i2c_clk", 32'(i2c_clk), 32'h0);
        chk("mid_rst_data", eng_data, 32'h0);
        respq.delete();
        gq.delete();
        rq0.delete();
        repeat (3) @(negedge clk_24M);
        cfg_hang = 1'b0;
        camera_rstn = 1'b1;
        repeat (2) @(negedge clk_24M);
        @(posedge clk_24M); #1;
        issue(0, 32'h600DCAFE, 1'b0, 10, -1, 1'b1);
        wait_done("after_reset", 400);

        chk("grant_q_empty", 32'(gq.size()), 32'h0);
        chk("resp_q_empty", 32'(respq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
